// File: rtl/axi_lite_master_bridge.sv
// Single-outstanding load/store request port to single-beat AXI4 master bridge.
// Includes the AXI payload package; a watchdog turns a stalled slave into an error response.

package axi_pkg;
  localparam int unsigned AXI_AW  = 32;
  localparam int unsigned AXI_DW  = 32;
  localparam int unsigned AXI_SW  = AXI_DW / 8;
  localparam int unsigned AXI_IDW = 4;
  localparam int unsigned AXI_UW  = 1;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

  typedef struct packed {
    logic [AXI_IDW-1:0] awid;
    logic [AXI_AW-1:0]  awaddr;
    logic [7:0]         awlen;
    logic [2:0]         awsize;
    logic [1:0]         awburst;
    logic               awlock;
    logic [3:0]         awcache;
    logic [2:0]         awprot;
    logic [3:0]         awqos;
    logic [3:0]         awregion;
    logic [AXI_UW-1:0]  awuser;
    logic               awvalid;
    logic [AXI_DW-1:0]  wdata;
    logic [AXI_SW-1:0]  wstrb;
    logic               wlast;
    logic [AXI_UW-1:0]  wuser;
    logic               wvalid;
    logic               bready;
    logic [AXI_IDW-1:0] arid;
    logic [AXI_AW-1:0]  araddr;
    logic [7:0]         arlen;
    logic [2:0]         arsize;
    logic [1:0]         arburst;
    logic               arlock;
    logic [3:0]         arcache;
    logic [2:0]         arprot;
    logic [3:0]         arqos;
    logic [3:0]         arregion;
    logic [AXI_UW-1:0]  aruser;
    logic               arvalid;
    logic               rready;
  } s_axi_mosi_t;

  typedef struct packed {
    logic               awready;
    logic               wready;
    logic [AXI_IDW-1:0] bid;
    logic [1:0]         bresp;
    logic [AXI_UW-1:0]  buser;
    logic               bvalid;
    logic               arready;
    logic [AXI_IDW-1:0] rid;
    logic [AXI_DW-1:0]  rdata;
    logic [1:0]         rresp;
    logic               rlast;
    logic [AXI_UW-1:0]  ruser;
    logic               rvalid;
  } s_axi_miso_t;
endpackage

module axi_lite_master_bridge
  import axi_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned TW          = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  input  logic        req_we_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_wstrb_i,
  input  logic [1:0]  req_size_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        busy_o,
  output s_axi_mosi_t axi_mosi_o,
  input  s_axi_miso_t axi_miso_i
);

  typedef enum logic [2:0] {IDLE, WR, WR_B, RD_AR, RD_R, RSP} state_e;

  state_e        state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic          we_q, we_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic [1:0]    size_q, size_d;
  logic          aw_done_q, aw_done_d;
  logic          w_done_q, w_done_d;
  logic [TW-1:0] wdog_q, wdog_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  logic          timeout_c, aw_valid_c, w_valid_c, aw_hs_c, w_hs_c, wait_c;
  logic [31:0]   shifted_c, aligned_c;
  logic          unused_miso_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      size_q    <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      wdog_q    <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      size_q    <= size_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      wdog_q    <= wdog_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  assign timeout_c  = (TIMEOUT_CYC != 0) && (wdog_q == TW'(TIMEOUT_CYC));
  assign aw_valid_c = (state_q == WR) && !aw_done_q && !timeout_c;
  assign w_valid_c  = (state_q == WR) && !w_done_q && !timeout_c;
  assign aw_hs_c    = aw_valid_c && axi_miso_i.awready;
  assign w_hs_c     = w_valid_c && axi_miso_i.wready;
  assign wait_c     = (state_q == WR) || (state_q == WR_B) ||
                      (state_q == RD_AR) || (state_q == RD_R);

  // Right-align the addressed lanes and zero everything above the access size.
  always_comb begin
    shifted_c = axi_miso_i.rdata >> {addr_q[1:0], 3'b000};
    case (size_q)
      2'd0:    aligned_c = {24'd0, shifted_c[7:0]};
      2'd1:    aligned_c = {16'd0, shifted_c[15:0]};
      default: aligned_c = shifted_c;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    size_d    = size_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    wdog_d    = wdog_q;
    rdata_d   = rdata_q;
    err_d     = err_q;

    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          addr_d    = req_addr_i;
          we_d      = req_we_i;
          wdata_d   = req_wdata_i;
          wstrb_d   = req_wstrb_i;
          size_d    = req_size_i;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = req_we_i ? WR : RD_AR;
        end
      end
      WR: begin
        if (timeout_c) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = RSP;
        end else begin
          if (aw_hs_c) aw_done_d = 1'b1;
          if (w_hs_c)  w_done_d  = 1'b1;
          if ((aw_done_q || aw_hs_c) && (w_done_q || w_hs_c)) state_d = WR_B;
        end
      end
      WR_B: begin
        if (timeout_c) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = RSP;
        end else if (axi_miso_i.bvalid) begin
          err_d   = (axi_miso_i.bresp != AXI_RESP_OKAY);
          rdata_d = '0;
          state_d = RSP;
        end
      end
      RD_AR: begin
        if (timeout_c) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = RSP;
        end else if (axi_miso_i.arready) begin
          state_d = RD_R;
        end
      end
      RD_R: begin
        if (timeout_c) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = RSP;
        end else if (axi_miso_i.rvalid) begin
          err_d   = (axi_miso_i.rresp != AXI_RESP_OKAY);
          rdata_d = aligned_c;
          state_d = RSP;
        end
      end
      RSP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Any forward progress restarts the wait budget.
    if ((state_d != state_q) || aw_hs_c || w_hs_c) begin
      wdog_d = '0;
    end else if (wait_c) begin
      wdog_d = wdog_q + TW'(1);
    end
  end

  always_comb begin
    axi_mosi_o          = '0;
    axi_mosi_o.awaddr   = addr_q;
    axi_mosi_o.awlen    = 8'd0;
    axi_mosi_o.awsize   = 3'(size_q);
    axi_mosi_o.awburst  = AXI_BURST_INCR;
    axi_mosi_o.awvalid  = aw_valid_c;
    axi_mosi_o.wdata    = wdata_q;
    axi_mosi_o.wstrb    = wstrb_q;
    axi_mosi_o.wlast    = 1'b1;
    axi_mosi_o.wvalid   = w_valid_c;
    axi_mosi_o.bready   = (state_q == WR_B) && !timeout_c;
    axi_mosi_o.araddr   = addr_q;
    axi_mosi_o.arlen    = 8'd0;
    axi_mosi_o.arsize   = 3'(size_q);
    axi_mosi_o.arburst  = AXI_BURST_INCR;
    axi_mosi_o.arvalid  = (state_q == RD_AR) && !timeout_c;
    axi_mosi_o.rready   = (state_q == RD_R) && !timeout_c;
  end

  assign req_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign rsp_valid_o = (state_q == RSP);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

  // IDs, user bits and rlast carry no information for single-beat, ID-0 traffic.
  assign unused_miso_c = ^{axi_miso_i.bid, axi_miso_i.buser, axi_miso_i.rid,
                           axi_miso_i.rlast, axi_miso_i.ruser, we_q};

endmodule

// File: tb/tb_axi_lite_master_bridge.sv
// Directed bench for axi_lite_master_bridge with a small AXI slave model and knobs
// for stalls, error responses, forced read data and stray R beats.

module tb_axi_lite_master_bridge;
  import axi_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic [1:0]  req_size;
  logic        rsp_valid, rsp_ready, rsp_err, busy;
  logic [31:0] rsp_rdata;
  s_axi_mosi_t mosi;
  s_axi_miso_t miso;

  int passed = 0;
  int total  = 0;

  // Slave knobs, written only by the test tasks.
  logic        aw_block, ar_block, force_en, stray;
  logic [1:0]  bresp_k, rresp_k;
  logic [31:0] force_data;

  // Slave state.
  logic        s_bvalid, s_rvalid, s_got_aw, s_got_w;
  logic [31:0] s_rdata, s_aw_addr, s_wdata;
  logic [3:0]  s_wstrb;
  int          b_count;
  logic [31:0] mem [0:63];

  always #5 clk = ~clk;

  axi_lite_master_bridge #(.TIMEOUT_CYC(8), .TW(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .req_we_i(req_we), .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb),
    .req_size_i(req_size), .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err), .busy_o(busy),
    .axi_mosi_o(mosi), .axi_miso_i(miso)
  );

  always_comb begin
    miso         = '0;
    miso.awready = !aw_block;
    miso.wready  = 1'b1;
    miso.bresp   = bresp_k;
    miso.bvalid  = s_bvalid;
    miso.arready = !ar_block;
    miso.rdata   = s_rdata;
    miso.rresp   = rresp_k;
    miso.rlast   = 1'b1;
    miso.rvalid  = s_rvalid;
  end

  always @(posedge clk) begin : slave
    logic        aw_hs, w_hs;
    logic [31:0] a, d;
    logic [3:0]  s;
    if (rst) begin
      s_bvalid <= 1'b0; s_rvalid <= 1'b0; s_got_aw <= 1'b0; s_got_w <= 1'b0;
      s_rdata  <= '0;   b_count  <= 0;
    end else begin
      aw_hs = mosi.awvalid && miso.awready;
      w_hs  = mosi.wvalid && miso.wready;
      a = aw_hs ? mosi.awaddr : s_aw_addr;
      d = w_hs ? mosi.wdata : s_wdata;
      s = w_hs ? mosi.wstrb : s_wstrb;
      if (aw_hs) begin s_got_aw <= 1'b1; s_aw_addr <= mosi.awaddr; end
      if (w_hs) begin s_got_w <= 1'b1; s_wdata <= mosi.wdata; s_wstrb <= mosi.wstrb; end
      if ((s_got_aw || aw_hs) && (s_got_w || w_hs)) begin
        for (int i = 0; i < 4; i++) if (s[i]) mem[a[7:2]][8*i +: 8] <= d[8*i +: 8];
        s_got_aw <= 1'b0; s_got_w <= 1'b0; s_bvalid <= 1'b1;
      end
      if (s_bvalid && mosi.bready) begin s_bvalid <= 1'b0; b_count <= b_count + 1; end
      if (mosi.arvalid && miso.arready) begin
        s_rvalid <= 1'b1;
        s_rdata  <= force_en ? force_data : mem[mosi.araddr[7:2]];
      end else if (stray) begin
        s_rvalid <= 1'b1;
        s_rdata  <= 32'hFFFF_FFFF;
      end
      if (s_rvalid && mosi.rready) s_rvalid <= 1'b0;
    end
  end

  // Issue one request and wait for its response; lat = cycles from acceptance to rsp_valid.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input logic [1:0] size,
                        output int lat, output logic [31:0] rdata, output logic err);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    req_wstrb = strb; req_size = size;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      req_valid = 1'b0;
    end while (!rsp_valid && lat < 100);
    rdata = rsp_rdata;
    err   = rsp_err;
    if (!rsp_valid) lat = -1;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({busy, req_ready, rsp_valid, rsp_err} !== 4'b0100) begin
      $display("FAIL reset_ctrl: busy/ready/rsp_valid/err got %b want 0100", {busy, req_ready, rsp_valid, rsp_err});
    end else passed++;
    total++;
    if (rsp_rdata !== 32'h0) $display("FAIL reset_rdata: got %h want 00000000", rsp_rdata);
    else passed++;
    total++;
    if ({mosi.awvalid, mosi.wvalid, mosi.bready, mosi.arvalid, mosi.rready} !== 5'b0) begin
      $display("FAIL reset_axi: valids/readies got %b want 00000",
               {mosi.awvalid, mosi.wvalid, mosi.bready, mosi.arvalid, mosi.rready});
    end else passed++;
  endtask

  task automatic test_write_read();
    int lat; logic [31:0] rd; logic err;
    do_req(1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 2'd2, lat, rd, err);
    total++;
    if ({lat, rd, err} !== {32'd3, 32'h0, 1'b0}) begin
      $display("FAIL wr_word: lat=%0d rdata=%h err=%b want lat=3 rdata=0 err=0", lat, rd, err);
    end else passed++;
    do_req(1'b0, 32'h100, 32'h0, 4'h0, 2'd2, lat, rd, err);
    total++;
    if ({lat, rd, err} !== {32'd3, 32'hDEADBEEF, 1'b0}) begin
      $display("FAIL rd_word: lat=%0d rdata=%h err=%b want lat=3 rdata=deadbeef err=0", lat, rd, err);
    end else passed++;
  endtask

  task automatic test_align();
    int lat; logic [31:0] rd; logic err;
    force_en = 1'b1;
    force_data = 32'hAB00_0000;
    do_req(1'b0, 32'h103, 32'h0, 4'h0, 2'd0, lat, rd, err);
    total++;
    if (rd !== 32'h0000_00AB) $display("FAIL rd_byte3: got %h want 000000ab", rd);
    else passed++;
    force_data = 32'h1234_0000;
    do_req(1'b0, 32'h102, 32'h0, 4'h0, 2'd1, lat, rd, err);
    total++;
    if (rd !== 32'h0000_1234) $display("FAIL rd_half2: got %h want 00001234", rd);
    else passed++;
    force_data = 32'hFFFF_ABFF;
    do_req(1'b0, 32'h101, 32'h0, 4'h0, 2'd0, lat, rd, err);
    total++;
    if (rd !== 32'h0000_00AB) $display("FAIL rd_byte1_mask: got %h want 000000ab", rd);
    else passed++;
    force_en = 1'b0;
  endtask

  task automatic test_aw_stall();
    int lat, bc0; logic [31:0] rd; logic err; logic held; logic extra;
    bc0 = b_count;
    aw_block = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h200; req_wdata = 32'h1122_3344;
    req_wstrb = 4'hF; req_size = 2'd2;
    @(negedge clk);
    req_valid = 1'b0;
    total++;
    if ({mosi.awvalid, mosi.wvalid, mosi.awaddr, mosi.awlen, mosi.awsize, mosi.awburst, mosi.wlast} !==
        {1'b1, 1'b1, 32'h200, 8'd0, 3'd2, 2'b01, 1'b1}) begin
      $display("FAIL aw_fields: awv=%b wv=%b addr=%h len=%h size=%h burst=%b wlast=%b",
               mosi.awvalid, mosi.wvalid, mosi.awaddr, mosi.awlen, mosi.awsize, mosi.awburst, mosi.wlast);
    end else passed++;
    @(negedge clk);
    total++;
    if ({mosi.awvalid, mosi.wvalid} !== 2'b10) begin
      $display("FAIL w_first: awvalid/wvalid got %b want 10", {mosi.awvalid, mosi.wvalid});
    end else passed++;
    held = 1'b1;
    lat = 2;
    for (int c = 3; c <= 6; c++) begin
      @(negedge clk);
      lat++;
      if (mosi.awvalid !== 1'b1 || mosi.wvalid !== 1'b0) held = 1'b0;
    end
    aw_block = 1'b0;
    total++;
    if (held !== 1'b1) $display("FAIL aw_hold: awvalid dropped or wvalid reasserted while stalled");
    else passed++;
    while (!rsp_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    total++;
    if ({lat, rsp_err} !== {32'd8, 1'b0}) $display("FAIL aw_stall_rsp: lat=%0d err=%b want lat=8 err=0", lat, rsp_err);
    else passed++;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    extra = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid) extra = 1'b1;
    end
    total++;
    if ({b_count - bc0, 31'd0, extra} !== {32'd1, 31'd0, 1'b0}) begin
      $display("FAIL aw_stall_once: b_beats=%0d extra_rsp=%b want 1 and 0", b_count - bc0, extra);
    end else passed++;
    do_req(1'b0, 32'h200, 32'h0, 4'h0, 2'd2, lat, rd, err);
    total++;
    if (rd !== 32'h1122_3344) $display("FAIL aw_stall_data: got %h want 11223344", rd);
    else passed++;
  endtask

  task automatic test_errors();
    int lat; logic [31:0] rd; logic err;
    bresp_k = AXI_RESP_SLVERR;
    do_req(1'b1, 32'h20, 32'hCAFE_F00D, 4'hF, 2'd2, lat, rd, err);
    bresp_k = AXI_RESP_OKAY;
    total++;
    if ({err, rd} !== {1'b1, 32'h0}) $display("FAIL wr_slverr: err=%b rdata=%h want 1/00000000", err, rd);
    else passed++;
    rresp_k = AXI_RESP_DECERR;
    do_req(1'b0, 32'h20, 32'h0, 4'h0, 2'd2, lat, rd, err);
    rresp_k = AXI_RESP_OKAY;
    total++;
    if (err !== 1'b1) $display("FAIL rd_decerr: err=%b want 1", err);
    else passed++;
    do_req(1'b0, 32'h20, 32'h0, 4'h0, 2'd2, lat, rd, err);
    total++;
    if ({err, rd} !== {1'b0, 32'hCAFE_F00D}) $display("FAIL rd_after_err: err=%b rdata=%h want 0/cafef00d", err, rd);
    else passed++;
  endtask

  task automatic test_rsp_hold();
    int lat;
    force_en = 1'b1;
    force_data = 32'h5A5A_1234;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0; req_size = 2'd2;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      req_valid = 1'b0;
    end while (!rsp_valid && lat < 60);
    force_en = 1'b0;
    for (int c = 0; c < 4; c++) begin
      total++;
      if ({rsp_valid, rsp_rdata, rsp_err, req_ready} !== {1'b1, 32'h5A5A_1234, 1'b0, 1'b0}) begin
        $display("FAIL rsp_hold[%0d]: valid=%b rdata=%h err=%b req_ready=%b", c, rsp_valid, rsp_rdata, rsp_err, req_ready);
      end else passed++;
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_rst_mid();
    logic seen;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h7777_7777;
    req_wstrb = 4'hF; req_size = 2'd2;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({busy, mosi.bready} !== 2'b11) $display("FAIL rst_pre_wrb: busy/bready got %b want 11", {busy, mosi.bready});
    else passed++;
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({busy, req_ready, rsp_valid, rsp_err, rsp_rdata} !== {4'b0100, 32'h0}) begin
      $display("FAIL rst_mid_outs: busy/ready/valid/err=%b rdata=%h want 0100/00000000",
               {busy, req_ready, rsp_valid, rsp_err}, rsp_rdata);
    end else passed++;
    total++;
    if ({mosi.awvalid, mosi.wvalid, mosi.bready, mosi.arvalid, mosi.rready} !== 5'b0) begin
      $display("FAIL rst_mid_axi: got %b want 00000", {mosi.awvalid, mosi.wvalid, mosi.bready, mosi.arvalid, mosi.rready});
    end else passed++;
    rst = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) $display("FAIL rst_mid_norsp: response appeared after reset");
    else passed++;
  endtask

  task automatic test_timeout();
    int lat, cnt; logic bad;
    ar_block = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h300; req_size = 2'd2;
    lat = 0; cnt = 0;
    do begin
      @(negedge clk);
      lat++;
      req_valid = 1'b0;
      if (mosi.arvalid) cnt++;
    end while (!rsp_valid && lat < 40);
    total++;
    if ({cnt, lat} !== {32'd8, 32'd10}) $display("FAIL timeout_len: arvalid_cycles=%0d lat=%0d want 8/10", cnt, lat);
    else passed++;
    total++;
    if ({rsp_valid, rsp_err, rsp_rdata, mosi.arvalid} !== {1'b1, 1'b1, 32'h0, 1'b0}) begin
      $display("FAIL timeout_rsp: valid=%b err=%b rdata=%h arvalid=%b want 1/1/00000000/0",
               rsp_valid, rsp_err, rsp_rdata, mosi.arvalid);
    end else passed++;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    ar_block = 1'b0;
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    bad = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid || mosi.rready || !miso.rvalid) bad = 1'b1;
    end
    total++;
    if (bad !== 1'b0) $display("FAIL stray_r: late R beat was consumed or produced a response");
    else passed++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_wstrb = '0; req_size = '0; rsp_ready = 1'b0;
    aw_block = 1'b0; ar_block = 1'b0; force_en = 1'b0; stray = 1'b0;
    bresp_k = AXI_RESP_OKAY; rresp_k = AXI_RESP_OKAY; force_data = '0;
    test_reset();
    test_write_read();
    test_align();
    test_aw_stall();
    test_errors();
    test_rsp_hold();
    test_rst_mid();
    test_timeout();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
